// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared sizes and sequencer state encoding for the AES-256
//               key schedule controller.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR_RK   = 15;
    localparam int NR_STEP = 7;
    localparam int RK_W    = 128;
    localparam int KEY_W   = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN1   = 3'd1,
        EN2   = 3'd2,
        CAP   = 3'd3,
        READY = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/aes256_key_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes256_key_sched_ctrl_if
// Description : Key load and round-key read bus of the key schedule controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes256_key_sched_ctrl_if;
    import aes_pkg::*;

    logic               iStart;
    logic [0:KEY_W-1]   iKey;
    logic [3:0]         iRkIdx;
    logic [0:RK_W-1]    oRk;
    logic               oBusy;
    logic               oReady;

    modport slave (
        input  iStart, iKey, iRkIdx,
        output oRk, oBusy, oReady
    );

    modport master (
        output iStart, iKey, iRkIdx,
        input  oRk, oBusy, oReady
    );

endinterface
`default_nettype wire

// File: rtl/aes_rk_buffer.sv
`default_nettype none
// ============================================================================
// Module      : aes_rk_buffer
// Description : Round-key register file, two write ports, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rk_buffer
    import aes_pkg::*;
#(
    parameter int DEPTH = 15
) (
    input  wire logic              iClk,
    input  wire logic              iRst,
    input  wire logic              iWeA,
    input  wire logic [3:0]        iAddrA,
    input  wire logic [0:RK_W-1]   iDataA,
    input  wire logic              iWeB,
    input  wire logic [3:0]        iAddrB,
    input  wire logic [0:RK_W-1]   iDataB,
    input  wire logic [3:0]        iRdIdx,
    output logic      [0:RK_W-1]   oRdData
);

    logic [0:RK_W-1] rMem [DEPTH];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rMem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (iWeA && (iAddrA == 4'(i))) begin
                    rMem[i] <= iDataA;
                end else if (iWeB && (iAddrB == 4'(i))) begin
                    rMem[i] <= iDataB;
                end
            end
        end
    end

    // Out-of-range indices read back as zero rather than an undefined entry.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oRdData <= '0;
        end else if (iRdIdx < 4'(DEPTH)) begin
            oRdData <= rMem[iRdIdx];
        end else begin
            oRdData <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes256_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes256_key_sched_ctrl
// Description : Steps the external AES-256 expansion datapath and buffers the
//               15 round keys for the round pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module aes256_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR_RK   = aes_pkg::NR_RK,
    parameter int NR_STEP = aes_pkg::NR_STEP
) (
    input  wire logic               iClk,
    input  wire logic               iRst,
    aes256_key_sched_ctrl_if.slave  bus,
    output logic                    oExpEn,
    output logic      [3:0]         oExpCnt,
    output logic      [0:KEY_W-1]   oExpKey,
    input  wire logic [0:KEY_W-1]   iExpKey
);

    state_t            rState;
    state_t            wStateNext;
    logic [0:KEY_W-1]  rCur;
    logic [2:0]        rStep;
    logic              rBusy;
    logic              rReady;

    logic              wAccept;
    logic              wCapMid;
    logic              wCapLast;
    logic              wWeA;
    logic              wWeB;
    logic [3:0]        wAddrA;
    logic [3:0]        wAddrB;
    logic [0:RK_W-1]   wDataA;
    logic [0:RK_W-1]   wDataB;

    assign wAccept  = bus.iStart && ((rState == IDLE) || (rState == READY));
    assign wCapMid  = (rState == CAP) && (rStep <  3'(NR_STEP));
    assign wCapLast = (rState == CAP) && (rStep == 3'(NR_STEP));

    always_comb begin
        wStateNext = rState;
        case (rState)
            IDLE, READY: if (bus.iStart) wStateNext = EN1;
            EN1:         wStateNext = EN2;
            EN2:         wStateNext = CAP;
            CAP:         wStateNext = wCapLast ? READY : EN1;
            default:     wStateNext = IDLE;
        endcase
    end

    // Even/odd round keys of a step land through ports A/B; the last step
    // produces only the even one.
    always_comb begin
        wWeA   = 1'b0;
        wWeB   = 1'b0;
        wAddrA = 4'd0;
        wAddrB = 4'd1;
        wDataA = bus.iKey[0:RK_W-1];
        wDataB = bus.iKey[RK_W:KEY_W-1];
        if (wAccept) begin
            wWeA = 1'b1;
            wWeB = 1'b1;
        end else if (rState == CAP) begin
            wWeA   = 1'b1;
            wWeB   = wCapMid;
            wAddrA = {rStep, 1'b0};
            wAddrB = {rStep, 1'b1};
            wDataA = iExpKey[0:RK_W-1];
            wDataB = iExpKey[RK_W:KEY_W-1];
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rState  <= IDLE;
            rCur    <= '0;
            rStep   <= 3'd0;
            oExpCnt <= 4'd0;
            oExpEn  <= 1'b0;
            rBusy   <= 1'b0;
            rReady  <= 1'b0;
        end else begin
            rState <= wStateNext;
            oExpEn <= (wStateNext == EN1) || (wStateNext == EN2);
            rBusy  <= (wStateNext == EN1) || (wStateNext == EN2) || (wStateNext == CAP);
            rReady <= (wStateNext == READY);
            if (wAccept) begin
                rCur    <= bus.iKey;
                rStep   <= 3'd1;
                oExpCnt <= 4'd0;
            end else if (wCapMid) begin
                rCur    <= iExpKey;
                rStep   <= rStep + 3'd1;
                oExpCnt <= oExpCnt + 4'd1;
            end
        end
    end

    assign oExpKey    = rCur;
    assign bus.oBusy  = rBusy;
    assign bus.oReady = rReady;

    aes_rk_buffer #(
        .DEPTH   (NR_RK)
    ) u_rk_buffer (
        .iClk    (iClk),
        .iRst    (iRst),
        .iWeA    (wWeA),
        .iAddrA  (wAddrA),
        .iDataA  (wDataA),
        .iWeB    (wWeB),
        .iAddrB  (wAddrB),
        .iDataB  (wDataB),
        .iRdIdx  (bus.iRkIdx),
        .oRdData (bus.oRk)
    );

endmodule
`default_nettype wire
